bcd_delay_timer: RTL and testbench
==================================

# bcd_delay_timer

Parametrised N-digit BCD timer for the reaction-timer datapath. It runs in one of two modes. WAIT mode counts up to a programmed BCD target and flags completion, which gives the random pre-stimulus delay. MEASURE mode counts until `stop` and holds the elapsed value for the display. A built-in prescaler generates the count tick, and overflow and bad-target errors are reported through explicit status outputs.

## Interface
Parameters:
- NUM_DIGITS, 4: number of BCD digits; digit 0 is least significant.
- TICK_DIV, 100000: clk cycles per count tick (1 ms at 100 MHz); must be ≥ 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- clr  in  1  synchronous clear: returns to IDLE and zeroes digits and errors.
- start  in  1  level sampled each cycle; begins a run.
- stop  in  1  level sampled each cycle; ends a run.
- mode  in  1  0 = WAIT, 1 = MEASURE; sampled on accepted start.
- target  in  4*NUM_DIGITS  BCD compare value for WAIT; sampled on accepted start.
- digits  out  4*NUM_DIGITS  current BCD count; digit i is bits [4i+3:4i].
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on successful completion.
- error_long_delay  out  1  sticky; set when the count saturates at all 9s.
- bad_target  out  1  one-cycle pulse when a WAIT start is rejected.

## Operation
- States: IDLE, RUN, DONE, ERROR.
- Reset values: state IDLE, digits 0, prescaler 0, all outputs 0.
- Priority, highest first: rst, clr, then the state logic.
- IDLE / DONE / ERROR:
  - start=1 with mode=1, or with mode=0 and every target nibble ≤ 9, is accepted.
  - On accept: latch mode and target, zero digits and prescaler, clear error_long_delay, go to RUN.
  - A WAIT start where any target nibble is > 9 is rejected: pulse bad_target, stay in the current state.
  - stop is ignored in these states.
- RUN:
  - The prescaler increments every cycle. It wraps to 0 and generates a tick in the cycle where it equals TICK_DIV-1.
  - On a tick, digits increment as a BCD ripple. Every digit is updated in the same cycle: each 9 that carries becomes 0 and passes a carry to the next digit.
  - start is ignored in RUN.
- Overflow: a tick while every digit is 9 leaves digits at all 9s, sets error_long_delay, and goes to ERROR. No done pulse.
- WAIT completion: in any RUN cycle where the registered digits equal the latched target, go to DONE and pulse done. A target of 0 therefore completes in the first RUN cycle.
- stop in RUN:
  - MEASURE: go to DONE, pulse done, freeze digits.
  - WAIT: abort to IDLE with digits frozen and no done pulse.
- Digits hold their value in IDLE, DONE and ERROR until the next accepted start or clr.
- clr: state IDLE, digits 0, prescaler 0, error_long_delay 0. Pulses are suppressed.

## Timing
- Accepted start at cycle 0: RUN and busy=1 from cycle 1.
- The first tick occurs in cycle TICK_DIV; digits read 1 from cycle TICK_DIV+1. Count k is visible from cycle k·TICK_DIV+1.
- WAIT with target T > 0: digits reach T in cycle T·TICK_DIV+1. done pulses and state becomes DONE in cycle T·TICK_DIV+2; busy falls in the same cycle.
- stop asserted in cycle s while in RUN: DONE (MEASURE) or IDLE (WAIT) from cycle s+1, and done pulses in cycle s+1 (MEASURE only).
- Simultaneous events:
  - stop and tick in the same cycle: stop wins and the increment is discarded.
  - stop and overflow tick: stop wins and no error is flagged.
  - WAIT target match and stop in the same cycle: the match wins (done pulses).
- Overflow tick in cycle c: error_long_delay=1 and state ERROR from cycle c+1.
- TICK_DIV=1: a tick occurs every RUN cycle.
- rst or clr mid-run takes effect on the next edge with no pulses.
- All outputs are registered.

## Test plan
- NUM_DIGITS=4, TICK_DIV=4, MEASURE. start at cycle 0, stop at cycle 50 → digits=0x0012, done pulse at cycle 51, busy low from cycle 51.
- TICK_DIV=1, WAIT, target=0x0123 → done pulse exactly at cycle 125, digits=0x0123; stop=0 throughout.
- TICK_DIV=1, MEASURE, no stop. digits reach 0x9999 by cycle 10000; the tick at cycle 10000 → error_long_delay=1 at cycle 10001, state ERROR, digits held at 0x9999. A new start clears the error.
- WAIT, target=0x00A5 → bad_target pulse for 1 cycle, busy stays 0, digits unchanged.
- Ripple carry, TICK_DIV=1, NUM_DIGITS=3, MEASURE: a stop while digits=0x099 stops the count there. Without the stop, 0x099 → 0x100 → 0x101 on consecutive cycles.
- Mid-run behaviour: clr at count 0x0007 → digits=0, IDLE next cycle, no done. Separately, start held high through RUN and DONE → restart occurs only on a start sampled in DONE.

Source files
------------

// File: rtl/bcd_delay_timer.sv
// N-digit BCD timer: WAIT mode counts to a target, MEASURE mode counts to stop.
// Built-in prescaler drives the count tick; overflow and bad targets are flagged.
module bcd_delay_timer #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    mode,
  input  logic [4*NUM_DIGITS-1:0] target,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    busy,
  output logic                    done,
  output logic                    error_long_delay,
  output logic                    bad_target
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          mode_q;
  logic [W-1:0]  target_q;

  logic          tick;
  logic          match;
  logic          all_nines;
  logic          target_ok;
  logic          carry;
  logic [3:0]    nib;
  logic [W-1:0]  digits_inc;

  // Tick, target match, BCD ripple increment and target validity
  always_comb begin
    tick       = (presc == P_LAST);
    match      = (digits == target_q);
    all_nines  = 1'b1;
    target_ok  = 1'b1;
    carry      = 1'b1;
    nib        = 4'd0;
    digits_inc = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib = digits[4*i +: 4];
      if (nib != 4'd9)
        all_nines = 1'b0;
      if (target[4*i +: 4] > 4'd9)
        target_ok = 1'b0;
      if (!carry) begin
        digits_inc[4*i +: 4] = nib;
      end else if (nib == 4'd9) begin
        digits_inc[4*i +: 4] = 4'd0;
      end else begin
        digits_inc[4*i +: 4] = nib + 4'd1;
        carry = 1'b0;
      end
    end
  end

  // Control FSM with registered outputs; match beats stop beats tick
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state            <= S_IDLE;
      digits           <= '0;
      presc            <= '0;
      mode_q           <= 1'b0;
      target_q         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error_long_delay <= 1'b0;
      bad_target       <= 1'b0;
    end else begin
      done       <= 1'b0;
      bad_target <= 1'b0;
      case (state)
        S_RUN: begin
          if (!mode_q && match) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (stop) begin
            busy <= 1'b0;
            if (mode_q) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else if (tick) begin
            presc <= '0;
            if (all_nines) begin
              state            <= S_ERROR;
              busy             <= 1'b0;
              error_long_delay <= 1'b1;
            end else begin
              digits <= digits_inc;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: begin
          if (start && (mode || target_ok)) begin
            mode_q           <= mode;
            target_q         <= target;
            digits           <= '0;
            presc            <= '0;
            error_long_delay <= 1'b0;
            busy             <= 1'b1;
            state            <= S_RUN;
          end else if (start) begin
            bad_target <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_delay_timer.sv
// Scoreboard bench: stimulus queues expected done/bad/error events,
// a negedge monitor pops and compares them as the DUTs raise them.
module tb_bcd_delay_timer;

  localparam int EV_DONE = 0;
  localparam int EV_BAD  = 1;
  localparam int EV_ERR  = 2;

  typedef struct packed {
    int          kind;
    logic [15:0] dig;
    longint      cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr;
  logic        a_start, a_stop, a_mode;
  logic [15:0] a_target, a_digits;
  logic        a_busy, a_done, a_err, a_bad;
  logic        b_start, b_stop, b_mode;
  logic [11:0] b_target, b_digits;
  logic        b_busy, b_done, b_err, b_bad;

  bcd_delay_timer #(.NUM_DIGITS(4), .TICK_DIV(1)) u_a (
    .clk(clk), .rst(rst), .clr(clr),
    .start(a_start), .stop(a_stop), .mode(a_mode),
    .target(a_target), .digits(a_digits), .busy(a_busy),
    .done(a_done), .error_long_delay(a_err), .bad_target(a_bad)
  );

  bcd_delay_timer #(.NUM_DIGITS(3), .TICK_DIV(4)) u_b (
    .clk(clk), .rst(rst), .clr(clr),
    .start(b_start), .stop(b_stop), .mode(b_mode),
    .target(b_target), .digits(b_digits), .busy(b_busy),
    .done(b_done), .error_long_delay(b_err), .bad_target(b_bad)
  );

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   nvec = 0;
  int   nmis = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic a_err_q = 1'b0;
  logic b_err_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s: got %h want %h at cycle %0d",
               name, act, want, cyc);
    end
  endtask

  task automatic cmp(input string tag, input bit have, input exp_t e,
                     input int kind, input logic [15:0] dig);
    nvec++;
    if (!have) begin
      nmis++;
      $display("FAIL %s: unexpected event kind %0d digits %h cycle %0d",
               tag, kind, dig, cyc);
    end else if (e.kind != kind || e.dig !== dig || e.cyc != cyc) begin
      nmis++;
      $display("FAIL %s: got kind %0d digits %h cycle %0d, want kind %0d digits %h cycle %0d",
               tag, kind, dig, cyc, e.kind, e.dig, e.cyc);
    end
  endtask

  task automatic pop_a(input int kind, input logic [15:0] dig);
    exp_t e = '0;
    bit   h = (qa.size() > 0);
    if (h) e = qa.pop_front();
    cmp("a_event", h, e, kind, dig);
  endtask

  task automatic pop_b(input int kind, input logic [15:0] dig);
    exp_t e = '0;
    bit   h = (qb.size() > 0);
    if (h) e = qb.pop_front();
    cmp("b_event", h, e, kind, dig);
  endtask

  task automatic push_a(input int kind, input logic [15:0] dig,
                        input longint c);
    exp_t e;
    e.kind = kind;
    e.dig  = dig;
    e.cyc  = c;
    qa.push_back(e);
  endtask

  task automatic push_b(input int kind, input logic [15:0] dig,
                        input longint c);
    exp_t e;
    e.kind = kind;
    e.dig  = dig;
    e.cyc  = c;
    qb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (a_done) pop_a(EV_DONE, a_digits);
      if (a_bad) pop_a(EV_BAD, a_digits);
      if (a_err && !a_err_q) pop_a(EV_ERR, a_digits);
      if (b_done) pop_b(EV_DONE, {4'd0, b_digits});
      if (b_bad) pop_b(EV_BAD, {4'd0, b_digits});
      if (b_err && !b_err_q) pop_b(EV_ERR, {4'd0, b_digits});
    end
    a_err_q = a_err;
    b_err_q = b_err;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  longint t0;

  initial begin
    rst = 1'b1; clr = 1'b0;
    a_start = 1'b0; a_stop = 1'b0; a_mode = 1'b0; a_target = '0;
    b_start = 1'b0; b_stop = 1'b0; b_mode = 1'b1; b_target = '0;
    step(3);
    rst = 1'b0;
    step(1);
    chk("rst_a_digits", {16'd0, a_digits}, 32'h0);
    chk("rst_a_busy", {31'd0, a_busy}, 32'h0);
    chk("rst_a_done", {31'd0, a_done}, 32'h0);
    chk("rst_a_err", {31'd0, a_err}, 32'h0);
    chk("rst_a_bad", {31'd0, a_bad}, 32'h0);
    chk("rst_b_digits", {20'd0, b_digits}, 32'h0);
    chk("rst_b_busy", {31'd0, b_busy}, 32'h0);

    // MEASURE, TICK_DIV=4, stop at cycle 50 -> 012
    t0 = cyc;
    b_start = 1'b1;
    push_b(EV_DONE, 16'h0012, t0 + 51);
    step(1); b_start = 1'b0;
    chk("b_busy_run", {31'd0, b_busy}, 32'h1);
    step(49); b_stop = 1'b1;
    step(1); b_stop = 1'b0;
    chk("b_busy_done", {31'd0, b_busy}, 32'h0);
    chk("b_digits_stop", {20'd0, b_digits}, 32'h012);
    step(2);

    // WAIT target 0123, TICK_DIV=1 -> done 125 cycles after start
    t0 = cyc;
    a_mode = 1'b0; a_target = 16'h0123; a_start = 1'b1;
    push_a(EV_DONE, 16'h0123, t0 + 125);
    step(1); a_start = 1'b0;
    chk("wait_busy_run", {31'd0, a_busy}, 32'h1);
    step(124);
    chk("wait_busy_done", {31'd0, a_busy}, 32'h0);
    chk("wait_digits", {16'd0, a_digits}, 32'h0123);
    step(2);

    // Bad target 00A5: pulse, no run, digits kept
    t0 = cyc;
    a_target = 16'h00A5; a_start = 1'b1;
    push_a(EV_BAD, 16'h0123, t0 + 1);
    step(1); a_start = 1'b0;
    chk("bad_busy", {31'd0, a_busy}, 32'h0);
    chk("bad_digits", {16'd0, a_digits}, 32'h0123);
    step(1);
    chk("bad_busy2", {31'd0, a_busy}, 32'h0);

    // WAIT target 0 completes in first RUN cycle
    t0 = cyc;
    a_target = 16'h0000; a_start = 1'b1;
    push_a(EV_DONE, 16'h0000, t0 + 2);
    step(1); a_start = 1'b0;
    step(1);
    chk("zero_busy", {31'd0, a_busy}, 32'h0);
    step(1);

    // WAIT aborted by stop: IDLE, digits frozen, no done
    t0 = cyc;
    a_target = 16'h0050; a_start = 1'b1;
    step(1); a_start = 1'b0;
    step(9); a_stop = 1'b1;
    step(1); a_stop = 1'b0;
    chk("abort_busy", {31'd0, a_busy}, 32'h0);
    chk("abort_digits", {16'd0, a_digits}, 32'h0009);
    step(1);

    // MEASURE stop at 0099 freezes there
    t0 = cyc;
    a_mode = 1'b1; a_start = 1'b1;
    push_a(EV_DONE, 16'h0099, t0 + 101);
    step(1); a_start = 1'b0;
    step(99);
    chk("rip_stop_pre", {16'd0, a_digits}, 32'h0099);
    a_stop = 1'b1;
    step(1); a_stop = 1'b0;
    chk("rip_stop_digits", {16'd0, a_digits}, 32'h0099);
    chk("rip_stop_busy", {31'd0, a_busy}, 32'h0);
    step(1);

    // Ripple 0099 -> 0100 -> 0101
    t0 = cyc;
    a_start = 1'b1;
    push_a(EV_DONE, 16'h0101, t0 + 103);
    step(1); a_start = 1'b0;
    step(99);
    chk("rip_99", {16'd0, a_digits}, 32'h0099);
    step(1);
    chk("rip_100", {16'd0, a_digits}, 32'h0100);
    step(1);
    chk("rip_101", {16'd0, a_digits}, 32'h0101);
    a_stop = 1'b1;
    step(1); a_stop = 1'b0;
    step(1);

    // Overflow at 9999 -> ERROR, sticky error
    t0 = cyc;
    a_start = 1'b1;
    push_a(EV_ERR, 16'h9999, t0 + 10001);
    step(1); a_start = 1'b0;
    step(9999);
    chk("ovf_pre_digits", {16'd0, a_digits}, 32'h9999);
    chk("ovf_pre_err", {31'd0, a_err}, 32'h0);
    step(1);
    chk("ovf_err", {31'd0, a_err}, 32'h1);
    chk("ovf_busy", {31'd0, a_busy}, 32'h0);
    step(2);
    chk("ovf_hold_digits", {16'd0, a_digits}, 32'h9999);
    chk("ovf_hold_err", {31'd0, a_err}, 32'h1);

    // New start clears the error; clr at count 7
    t0 = cyc;
    a_start = 1'b1;
    step(1); a_start = 1'b0;
    chk("restart_err", {31'd0, a_err}, 32'h0);
    chk("restart_busy", {31'd0, a_busy}, 32'h1);
    step(7);
    chk("clr_pre", {16'd0, a_digits}, 32'h0007);
    clr = 1'b1;
    step(1); clr = 1'b0;
    chk("clr_digits", {16'd0, a_digits}, 32'h0);
    chk("clr_busy", {31'd0, a_busy}, 32'h0);
    step(1);

    // start held through RUN and DONE: restart only from DONE
    t0 = cyc;
    a_mode = 1'b0; a_target = 16'h0003; a_start = 1'b1;
    push_a(EV_DONE, 16'h0003, t0 + 5);
    push_a(EV_DONE, 16'h0003, t0 + 10);
    step(5);
    chk("held_busy_done", {31'd0, a_busy}, 32'h0);
    step(1);
    chk("held_busy_rerun", {31'd0, a_busy}, 32'h1);
    chk("held_digits_rerun", {16'd0, a_digits}, 32'h0);
    step(4); a_start = 1'b0;
    chk("held_busy_done2", {31'd0, a_busy}, 32'h0);
    step(3);
    chk("held_idle_busy", {31'd0, a_busy}, 32'h0);
    chk("held_idle_digits", {16'd0, a_digits}, 32'h0003);

    step(5);
    while (qa.size() > 0) begin
      exp_t e = qa.pop_front();
      nvec++; nmis++;
      $display("FAIL a_pending: got no event, want kind %0d digits %h cycle %0d",
               e.kind, e.dig, e.cyc);
    end
    while (qb.size() > 0) begin
      exp_t e = qb.pop_front();
      nvec++; nmis++;
      $display("FAIL b_pending: got no event, want kind %0d digits %h cycle %0d",
               e.kind, e.dig, e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
